// File: rtl/alu_pkg.sv
// Shared defaults and state encoding for the slice-serial subtractor.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice.sv
// SLICE-bit ripple-carry adder used once per cycle by the serial subtractor.
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_s,
  output logic             o_c
);

  logic [SLICE:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_c;
    for (int i = 0; i < SLICE; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_c = w_c[SLICE];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Computes a - b - bin one SLICE per cycle; results are published only on DONE entry
// so diff/bout/overflow hold steady across the following operation until it completes.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_a_sl = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_sl = r_b[r_cnt*SLICE +: SLICE];
  assign w_last = (r_cnt == CW'(NS - 1));

  // Subtraction as a + ~b + ~bin, carried slice to slice.
  sub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a (w_a_sl),
    .i_b (~w_b_sl),
    .i_c (r_carry),
    .o_s (w_sum),
    .o_c (w_cout)
  );

  always_comb begin
    w_acc_nxt                        = r_acc;
    w_acc_nxt[r_cnt*SLICE +: SLICE]  = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt   <= '0;
            r_carry <= ~bin;
          end
        end
        BUSY: begin
          r_carry <= w_cout;
          // Counter stops at the last slice rather than wrapping.
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_diff <= w_acc_nxt;
            r_bout <= ~w_cout;
            r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_acc_nxt[WIDTH-1] ^ r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and working registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
    end
    if (r_state == BUSY) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus a random stream
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        overflow;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] prev_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  // Returns {overflow, bout, diff} from plain unsigned and signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mbin);
    logic [32:0] u;
    longint      s;
    logic        ovf;
    u   = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    s   = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ovf, u[32], u[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic tbin,
                        input int stall);
    logic [33:0] m;
    int          cyc;
    m   = model(ta, tb_b, tbin);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb_b;
    bin      = tbin;
    in_valid = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (cyc == 4) check("diff_hold_busy", diff, prev_diff);
      a        = $urandom;
      b        = $urandom;
      bin      = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 32'd8);
    check("diff", diff, m[31:0]);
    check("bout", {31'd0, bout}, {31'd0, m[32]});
    check("overflow", {31'd0, overflow}, {31'd0, m[33]});
    for (int s = 0; s < stall; s++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'($urandom);
      @(negedge clk);
      check("diff_stall", diff, m[31:0]);
      check("in_ready_stall", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("diff_after_hs", diff, m[31:0]);
    prev_diff = m[31:0];
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    run_op(32'd5, 32'd3, 1'b0, 0);
    check("d_5m3", diff, 32'h0000_0002);
    run_op(32'd0, 32'd1, 1'b0, 1);
    check("d_0m1", diff, 32'hFFFF_FFFF);
    check("b_0m1", {31'd0, bout}, 32'd1);
    run_op(32'd10, 32'd3, 1'b1, 0);
    check("d_10m3m1", diff, 32'h0000_0006);
    run_op(32'h8000_0000, 32'd1, 1'b0, 2);
    check("o_min_m1", {31'd0, overflow}, 32'd1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("d_max_mneg1", diff, 32'h8000_0000);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5);

    // Abort an operation four cycles into BUSY.
    a        = 32'h1357_9BDF;
    b        = 32'h0000_0011;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_diff", diff, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    prev_diff = '0;
    run_op(32'd9, 32'd4, 1'b0, 0);
    check("d_9m4", diff, 32'd5);

    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
